// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing the architectural Hi/Lo registers.
// Define MD_UNSIGNED_EN to honour md_unsigned (MULTU/DIVU); otherwise every op is signed.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic             md_unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hiout,
    output logic [WIDTH-1:0] Loout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic               op_q, neg_q, sa_q, dz_q;

    logic               sgn, sa, sb;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;

`ifdef MD_UNSIGNED_EN
    assign sgn = ~md_unsigned;
`else
    logic unused_md;
    assign sgn = 1'b1;
    assign unused_md = md_unsigned;
`endif

    assign sa       = sgn & A[WIDTH-1];
    assign sb       = sgn & B[WIDTH-1];
    assign mag_a_in = sa ? -A : A;
    assign mag_b_in = sb ? -B : B;

    // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, mag_b};
    assign div_sub  = div_sh - {1'b0, mag_b};
    assign div_next = {div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0],
                       acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    // divide-by-zero skips iteration but still passes through FIX
                    if (op && B == '0) state_n = S_FIX;
                    else if (op)       state_n = S_DIV;
                    else               state_n = S_MUL;
                end
            end
            S_MUL,
            S_DIV:  if (cnt == '0) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            mag_b <= '0;
            op_q  <= 1'b0;
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
            dz_q  <= 1'b0;
            Hiout <= '0;
            Loout <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa_q  <= sa;
                        neg_q <= sa ^ sb;
                        dz_q  <= op && (B == '0);
                        mag_b <= mag_b_in;
                        acc   <= {{WIDTH{1'b0}}, mag_a_in};
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_DIV: begin
                    acc <= div_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (!dz_q) begin
                        if (op_q) begin
                            Hiout <= rem;
                            Loout <= quo;
                        end else begin
                            Hiout <= prod[2*WIDTH-1:WIDTH];
                            Loout <= prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign done     = (state == S_DONE);
    assign div_zero = done && dz_q;

endmodule
